branch_resolve_unit: RTL and testbench

//   Parametrised branch resolution stage for the ID/EX boundary. It evaluates all six
//   SB-type conditions (beq/bne/blt/bge/bltu/bgeu) over XLEN-wide operands and computes
//   the redirect PC. It also flags mispredictions against the fetch-stage prediction.

---
 rtl/branch_resolve_unit.sv | 138 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates SB-type conditions, computes the redirect PC,
// flags mispredictions and presents the result through one registered valid/ready
// stage. Saturating perf counters track accepted branches and mispredictions.
module branch_resolve_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16,
  parameter logic [6:0]  SB_OP = 7'h63
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             illegal,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [XLEN-1:0]  Four   = XLEN'(4);

  logic             out_valid_d, out_valid_q;
  logic             taken_d, taken_q;
  logic             mispredict_d, mispredict_q;
  logic             illegal_d, illegal_q;
  logic [XLEN-1:0]  redirect_pc_d, redirect_pc_q;
  logic [CNT_W-1:0] br_cnt_d, br_cnt_q;
  logic [CNT_W-1:0] mis_cnt_d, mis_cnt_q;

  logic            accept;
  logic            is_sb, eq, lt, ltu, cond, illegal_c, taken_c, mispredict_c;
  logic [XLEN-1:0] redirect_c;

  // Flush blocks acceptance so a same-cycle request is dropped entirely.
  assign in_ready = ~flush & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  assign is_sb = (op == SB_OP);
  assign eq    = (rs1_data == rs2_data);
  assign lt    = ($signed(rs1_data) < $signed(rs2_data));
  assign ltu   = (rs1_data < rs2_data);

  // Condition decode; funct3 2/3 are reserved encodings for SB-type ops.
  always_comb begin
    cond      = 1'b0;
    illegal_c = 1'b0;
    case (funct3)
      3'd0:    cond = eq;
      3'd1:    cond = ~eq;
      3'd4:    cond = lt;
      3'd5:    cond = ~lt;
      3'd6:    cond = ltu;
      3'd7:    cond = ~ltu;
      default: illegal_c = is_sb;
    endcase
    taken_c      = is_sb & cond;
    mispredict_c = taken_c ^ pred_taken;
    redirect_c   = taken_c ? (pc + imm) : (pc + Four);
  end

  // Next-state for the output stage and the perf counters.
  always_comb begin
    out_valid_d   = out_valid_q;
    taken_d       = taken_q;
    mispredict_d  = mispredict_q;
    illegal_d     = illegal_q;
    redirect_pc_d = redirect_pc_q;
    br_cnt_d      = br_cnt_q;
    mis_cnt_d     = mis_cnt_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Fields only move on accept, so they stay stable under backpressure.
    if (accept) begin
      taken_d       = taken_c;
      mispredict_d  = mispredict_c;
      illegal_d     = illegal_c;
      redirect_pc_d = redirect_c;
    end

    if (cnt_clr) begin
      br_cnt_d  = '0;
      mis_cnt_d = '0;
    end else if (accept) begin
      if (is_sb && br_cnt_q != CntMax) br_cnt_d = br_cnt_q + 1'b1;
      if (mispredict_c && mis_cnt_q != CntMax) mis_cnt_d = mis_cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      taken_q       <= 1'b0;
      mispredict_q  <= 1'b0;
      illegal_q     <= 1'b0;
      redirect_pc_q <= '0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      taken_q       <= taken_d;
      mispredict_q  <= mispredict_d;
      illegal_q     <= illegal_d;
      redirect_pc_q <= redirect_pc_d;
      br_cnt_q      <= br_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign taken       = taken_q;
  assign mispredict  = mispredict_q;
  assign illegal     = illegal_q;
  assign redirect_pc = redirect_pc_q;
  assign br_cnt      = br_cnt_q;
  assign mis_cnt     = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit with a behavioural reference model.
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;
  localparam logic [6:0] SB = 7'h63;
  localparam logic [6:0] ALU = 7'h13;

  logic             clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1_data, rs2_data, pc, imm, redirect_pc;
  logic             pred_taken, taken, mispredict, illegal, cnt_clr;
  logic [CNT_W-1:0] br_cnt, mis_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_br  = 0;
  int exp_mis = 0;

  typedef struct packed {
    logic        taken;
    logic        mis;
    logic        illegal;
    logic [31:0] rpc;
  } res_t;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W), .SB_OP(SB)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc),
    .imm(imm), .pred_taken(pred_taken), .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .illegal(illegal), .cnt_clr(cnt_clr), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: branch semantics from plain integer arithmetic.
  function automatic res_t model(input logic [6:0] o, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] p, input logic [31:0] i,
                                 input logic pr);
    res_t r;
    longint sa, sb, ua, ub;
    bit c;
    sa = (a >= 32'h8000_0000) ? longint'(a) - 64'sd4294967296 : longint'(a);
    sb = (b >= 32'h8000_0000) ? longint'(b) - 64'sd4294967296 : longint'(b);
    ua = longint'(a);
    ub = longint'(b);
    c = 1'b0;
    r.illegal = 1'b0;
    if (o == SB) begin
      if (f == 0) c = (ua == ub);
      else if (f == 1) c = (ua != ub);
      else if (f == 4) c = (sa < sb);
      else if (f == 5) c = (sa >= sb);
      else if (f == 6) c = (ua < ub);
      else if (f == 7) c = (ua >= ub);
      else r.illegal = 1'b1;
    end
    r.taken = c;
    r.mis   = (c != pr);
    r.rpc   = c ? 32'((longint'(p) + longint'(i)) % 64'd4294967296)
                : 32'((longint'(p) + 4) % 64'd4294967296);
    return r;
  endfunction

  // Counter model for one accepted request.
  function automatic void count(input logic [6:0] o, input logic m);
    if (o == SB && exp_br < CMAX) exp_br++;
    if (m && exp_mis < CMAX) exp_mis++;
  endfunction

  task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p, input logic [31:0] i,
                       input logic pr);
    op = o; funct3 = f; rs1_data = a; rs2_data = b; pc = p; imm = i; pred_taken = pr;
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    exp_br = 0; exp_mis = 0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    drive(SB, 3'd0, 0, 0, 0, 0, 1'b0);
    in_valid = 1'b0;
    #12;
    n_tests++;
    if ({out_valid, taken, mispredict, illegal, redirect_pc, br_cnt, mis_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got v%0b t%0b m%0b i%0b pc=%h br=%0d mis=%0d required all 0",
               out_valid, taken, mispredict, illegal, redirect_pc, br_cnt, mis_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %0b required 1", in_ready);
    end
    exp_br = 0; exp_mis = 0;
  endtask

  task automatic test_beq();
    res_t r;
    drive(SB, 3'd0, 32'h1234, 32'h1234, 32'h100, 32'h20, 1'b0);
    r = model(op, funct3, rs1_data, rs2_data, pc, imm, pred_taken);
    tick();
    count(op, r.mis);
    in_valid = 1'b0;
    n_tests++;
    if ({out_valid, taken, mispredict, redirect_pc} !== {1'b1, 1'b1, 1'b1, 32'h120}) begin
      n_fail++;
      $display("FAIL beq got v%0b t%0b m%0b pc=%h required v1 t1 m1 pc=00000120",
               out_valid, taken, mispredict, redirect_pc);
    end
    n_tests++;
    if (br_cnt !== 4'd1 || mis_cnt !== 4'd1) begin
      n_fail++; $display("FAIL beq_counts got br=%0d mis=%0d required 1 1", br_cnt, mis_cnt);
    end
    tick();
  endtask

  task automatic test_compare();
    logic [2:0] fs [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic       ex [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    res_t r;
    for (int k = 0; k < 4; k++) begin
      drive(SB, fs[k], 32'hFFFF_FFFF, 32'h1, 32'h400, 32'h40, 1'b0);
      r = model(op, funct3, rs1_data, rs2_data, pc, imm, pred_taken);
      tick();
      count(op, r.mis);
      n_tests++;
      if (taken !== ex[k] || r.taken !== ex[k]) begin
        n_fail++;
        $display("FAIL compare_f3_%0d got %0b required %0b", fs[k], taken, ex[k]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random_back_to_back();
    res_t r;
    logic [31:0] a;
    out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      a = $urandom;
      drive(($urandom_range(0, 3) == 0) ? ALU : SB, 3'($urandom_range(0, 7)), a,
            ($urandom_range(0, 2) == 0) ? a : $urandom, $urandom, $urandom,
            1'($urandom_range(0, 1)));
      r = model(op, funct3, rs1_data, rs2_data, pc, imm, pred_taken);
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_in_ready iter %0d got %0b required 1", k, in_ready);
      end
      tick();
      count(op, r.mis);
      n_tests++;
      if ({out_valid, taken, mispredict, illegal, redirect_pc} !==
          {1'b1, r.taken, r.mis, r.illegal, r.rpc}) begin
        n_fail++;
        $display("FAIL b2b_result iter %0d got v%0b t%0b m%0b i%0b pc=%h required v1 t%0b m%0b i%0b pc=%h",
                 k, out_valid, taken, mispredict, illegal, redirect_pc,
                 r.taken, r.mis, r.illegal, r.rpc);
      end
      n_tests++;
      if (int'(br_cnt) !== exp_br || int'(mis_cnt) !== exp_mis) begin
        n_fail++;
        $display("FAIL b2b_counts iter %0d got br=%0d mis=%0d required %0d %0d",
                 k, br_cnt, mis_cnt, exp_br, exp_mis);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    res_t ra, rb;
    clear_counts();
    out_ready = 1'b0;
    drive(SB, 3'd1, 32'h5, 32'h6, 32'h200, 32'h80, 1'b0);
    ra = model(op, funct3, rs1_data, rs2_data, pc, imm, pred_taken);
    tick();
    count(op, ra.mis);
    drive(SB, 3'd0, 32'h7, 32'h8, 32'h300, 32'h10, 1'b1);
    rb = model(op, funct3, rs1_data, rs2_data, pc, imm, pred_taken);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_in_ready cycle %0d got %0b required 0", k, in_ready);
      end
      tick();
      n_tests++;
      if ({out_valid, taken, mispredict, redirect_pc} !== {1'b1, ra.taken, ra.mis, ra.rpc}
          || int'(br_cnt) !== exp_br || int'(mis_cnt) !== exp_mis) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d got v%0b t%0b pc=%h br=%0d mis=%0d required v1 t%0b pc=%h br=%0d mis=%0d",
                 k, out_valid, taken, redirect_pc, br_cnt, mis_cnt, ra.taken, ra.rpc,
                 exp_br, exp_mis);
      end
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready got %0b required 1", in_ready);
    end
    tick();
    count(op, rb.mis);
    in_valid = 1'b0;
    n_tests++;
    if ({out_valid, taken, mispredict, redirect_pc} !== {1'b1, rb.taken, rb.mis, rb.rpc}
        || int'(br_cnt) !== exp_br || int'(mis_cnt) !== exp_mis) begin
      n_fail++;
      $display("FAIL bp_release got v%0b m%0b pc=%h br=%0d mis=%0d required v1 m%0b pc=%h br=%0d mis=%0d",
               out_valid, mispredict, redirect_pc, br_cnt, mis_cnt, rb.mis, rb.rpc,
               exp_br, exp_mis);
    end
    tick();
  endtask

  task automatic test_flush();
    res_t r;
    out_ready = 1'b0;
    drive(SB, 3'd0, 32'h1, 32'h1, 32'h500, 32'h8, 1'b0);
    r = model(op, funct3, rs1_data, rs2_data, pc, imm, pred_taken);
    tick();
    count(op, r.mis);
    drive(SB, 3'd0, 32'h2, 32'h2, 32'h600, 32'h8, 1'b0);
    flush = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_in_ready got rdy=%0b v=%0b required rdy=0 v=1", in_ready, out_valid);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_tests++;
    if (out_valid !== 1'b0 || int'(br_cnt) !== exp_br || int'(mis_cnt) !== exp_mis) begin
      n_fail++;
      $display("FAIL flush_drop got v=%0b br=%0d mis=%0d required v=0 br=%0d mis=%0d",
               out_valid, br_cnt, mis_cnt, exp_br, exp_mis);
    end
    tick();
  endtask

  task automatic test_saturate();
    clear_counts();
    for (int k = 0; k < 17; k++) begin
      drive(SB, 3'd0, 32'h9, 32'h9, 32'h1000, 32'h4, 1'b0);
      tick();
      count(op, 1'b1);
    end
    n_tests++;
    if (br_cnt !== 4'd15 || mis_cnt !== 4'd15 || exp_br != CMAX) begin
      n_fail++;
      $display("FAIL saturate got br=%0d mis=%0d required 15 15", br_cnt, mis_cnt);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; in_valid = 1'b0;
    exp_br = 0; exp_mis = 0;
    n_tests++;
    if (br_cnt !== 4'd0 || mis_cnt !== 4'd0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_wins got br=%0d mis=%0d v=%0b required 0 0 v=1",
               br_cnt, mis_cnt, out_valid);
    end
    tick();
  endtask

  task automatic test_wrap_illegal();
    drive(ALU, 3'd0, 32'h3, 32'h3, 32'hFFFF_FFFC, 32'h40, 1'b1);
    tick();
    count(op, 1'b1);
    n_tests++;
    if ({taken, mispredict, illegal, redirect_pc} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap got t%0b m%0b i%0b pc=%h required t0 m1 i0 pc=00000000",
               taken, mispredict, illegal, redirect_pc);
    end
    drive(SB, 3'd2, 32'h3, 32'h3, 32'h80, 32'h40, 1'b0);
    tick();
    count(op, 1'b0);
    in_valid = 1'b0;
    n_tests++;
    if ({taken, mispredict, illegal, redirect_pc} !== {1'b0, 1'b0, 1'b1, 32'h84}
        || int'(br_cnt) !== exp_br || int'(mis_cnt) !== exp_mis) begin
      n_fail++;
      $display("FAIL illegal got t%0b m%0b i%0b pc=%h br=%0d mis=%0d required t0 m0 i1 pc=00000084 br=%0d mis=%0d",
               taken, mispredict, illegal, redirect_pc, br_cnt, mis_cnt, exp_br, exp_mis);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(SB, 3'd1, 32'h1, 32'h2, 32'h700, 32'h8, 1'b0);
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || br_cnt !== 4'd0 || redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid got v=%0b br=%0d pc=%h required v=0 br=0 pc=0",
               out_valid, br_cnt, redirect_pc);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    exp_br = 0; exp_mis = 0;
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_after got v=%0b required 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_compare();
    test_random_back_to_back();
    test_backpressure();
    test_flush();
    test_saturate();
    test_wrap_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
